// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the WISC-15 core.
// Owns the PC, applies stall/redirect requests and sequences the halt.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OP   = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_commit_i,
    output logic [15:0] im_addr_o,
    output logic        im_rd_en_o,
    input  logic [15:0] im_instr_i,
    input  logic        im_ready_i,
    output logic [15:0] pc_o,
    output logic [15:0] if_id_instr_o,
    output logic [15:0] if_id_pc_o,
    output logic [15:0] if_id_pc1_o,
    output logic        if_id_valid_o,
    output logic        hlt_o
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ifIdInstr;
    logic [15:0] r_ifIdPc;
    logic [15:0] r_ifIdPc1;
    logic        r_ifIdValid;

    state_t      w_stateNext;
    logic [15:0] w_pcNext;
    logic [15:0] w_ifIdInstrNext;
    logic [15:0] w_ifIdPcNext;
    logic [15:0] w_ifIdPc1Next;
    logic        w_ifIdValidNext;
    logic [15:0] w_pcPlus1;

    assign w_pcPlus1 = r_pc + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_ifIdInstr <= 16'h0000;
            r_ifIdPc    <= 16'h0000;
            r_ifIdPc1   <= 16'h0000;
            r_ifIdValid <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_ifIdInstr <= w_ifIdInstrNext;
            r_ifIdPc    <= w_ifIdPcNext;
            r_ifIdPc1   <= w_ifIdPc1Next;
            r_ifIdValid <= w_ifIdValidNext;
        end
    end

    // Priority within a cycle: redirect, then stall, then fetch/drain.
    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_ifIdInstrNext = r_ifIdInstr;
        w_ifIdPcNext    = r_ifIdPc;
        w_ifIdPc1Next   = r_ifIdPc1;
        w_ifIdValidNext = r_ifIdValid;
        case (r_state)
            S_RUN: begin
                if (redirect_i) begin
                    w_pcNext        = redirect_pc_i;
                    w_ifIdValidNext = 1'b0;
                end else if (!stall_i) begin
                    if (!im_ready_i) begin
                        w_ifIdValidNext = 1'b0;
                    end else begin
                        w_ifIdInstrNext = im_instr_i;
                        w_ifIdPcNext    = r_pc;
                        w_ifIdPc1Next   = w_pcPlus1;
                        w_ifIdValidNext = 1'b1;
                        if (im_instr_i[15:12] == HLT_OP) begin
                            w_stateNext = S_DRAIN;
                        end else begin
                            w_pcNext = w_pcPlus1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // A redirect here means the HLT was on a wrong path.
                if (redirect_i) begin
                    w_pcNext        = redirect_pc_i;
                    w_ifIdValidNext = 1'b0;
                    w_stateNext     = S_RUN;
                end else if (!stall_i) begin
                    w_ifIdValidNext = 1'b0;
                    if (halt_commit_i) begin
                        w_stateNext = S_HALTED;
                    end
                end
            end
            S_HALTED: begin
                w_stateNext = S_HALTED;
            end
            default: begin
                w_stateNext = S_RUN;
            end
        endcase
    end

    assign pc_o          = r_pc;
    assign im_addr_o     = r_pc;
    assign im_rd_en_o    = (r_state == S_RUN);
    assign hlt_o         = (r_state == S_HALTED);
    assign if_id_instr_o = r_ifIdInstr;
    assign if_id_pc_o    = r_ifIdPc;
    assign if_id_pc1_o   = r_ifIdPc1;
    assign if_id_valid_o = r_ifIdValid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard of expected IF/ID entries
// is filled when a fetch is driven and drained as the DUT latches words.
module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc1;
    } ifid_t;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        halt_commit_i;
    logic [15:0] im_addr_o;
    logic        im_rd_en_o;
    logic [15:0] im_instr_i;
    logic        im_ready_i;
    logic [15:0] pc_o;
    logic [15:0] if_id_instr_o;
    logic [15:0] if_id_pc_o;
    logic [15:0] if_id_pc1_o;
    logic        if_id_valid_o;
    logic        hlt_o;

    logic [15:0] mem [0:255];
    ifid_t       expQ[$];
    ifid_t       lastExp;
    int          total;
    int          bad;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_commit_i (halt_commit_i),
        .im_addr_o     (im_addr_o),
        .im_rd_en_o    (im_rd_en_o),
        .im_instr_i    (im_instr_i),
        .im_ready_i    (im_ready_i),
        .pc_o          (pc_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc1_o   (if_id_pc1_o),
        .if_id_valid_o (if_id_valid_o),
        .hlt_o         (hlt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign im_instr_i = mem[im_addr_o[7:0]];

    task automatic checkVal(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchCycle(input logic [15:0] fpc, input logic [15:0] nextPc);
        ifid_t e;
        ifid_t got;
        e.instr = mem[fpc[7:0]];
        e.pc    = fpc;
        e.pc1   = fpc + 16'd1;
        expQ.push_back(e);
        tick();
        checkVal("fetch_valid", {47'd0, if_id_valid_o}, 48'd1);
        if (if_id_valid_o === 1'b1) begin
            got = {if_id_instr_o, if_id_pc_o, if_id_pc1_o};
            if (expQ.size() == 0) begin
                checkVal("fetch_unexpected", got, 48'd0);
            end else begin
                lastExp = expQ.pop_front();
                checkVal("fetch_ifid", got, lastExp);
            end
        end
        checkVal("fetch_pc", {32'd0, pc_o}, {32'd0, nextPc});
    endtask

    task automatic bubbleCycle(input logic [15:0] expPc);
        tick();
        checkVal("bubble_valid", {47'd0, if_id_valid_o}, 48'd0);
        checkVal("bubble_pc", {32'd0, pc_o}, {32'd0, expPc});
        checkVal("bubble_q", {16'd0, 32'(expQ.size())}, 48'd0);
    endtask

    task automatic holdCycle(input logic [15:0] expPc);
        tick();
        checkVal("hold_valid", {47'd0, if_id_valid_o}, 48'd1);
        checkVal("hold_ifid", {if_id_instr_o, if_id_pc_o, if_id_pc1_o}, lastExp);
        checkVal("hold_pc", {32'd0, pc_o}, {32'd0, expPc});
    endtask

    task automatic checkCtl(input string tag, input logic expRd, input logic expHlt);
        checkVal(tag, {46'd0, im_rd_en_o, hlt_o}, {46'd0, expRd, expHlt});
    endtask

    task automatic redirectTo(input logic [15:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        bubbleCycle(target);
        redirect_i    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        lastExp = '0;
        for (int i = 0; i < 256; i++) mem[i] = {8'h60, i[7:0]};
        mem[0]  = 16'h1123;
        mem[1]  = 16'h2234;
        mem[2]  = 16'h3345;
        mem[3]  = 16'h4456;
        mem[10] = 16'hF000;

        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
        halt_commit_i = 1'b0; im_ready_i = 1'b1;
        tick();
        tick();
        checkVal("reset_regs", {if_id_instr_o, if_id_pc_o, if_id_pc1_o}, 48'd0);
        checkVal("reset_pc", {32'd0, pc_o}, 48'd0);
        checkVal("reset_valid", {47'd0, if_id_valid_o}, 48'd0);
        checkCtl("reset_ctl", 1'b1, 1'b0);
        rst_n = 1'b1;

        // Back-to-back fetches from the reset PC.
        fetchCycle(16'd0, 16'd1);
        fetchCycle(16'd1, 16'd2);
        fetchCycle(16'd2, 16'd3);
        fetchCycle(16'd3, 16'd4);
        fetchCycle(16'd4, 16'd5);

        // Stall holds everything; redirect during stall wins.
        stall_i = 1'b1;
        holdCycle(16'd5);
        holdCycle(16'd5);
        redirectTo(16'h0040);
        stall_i = 1'b0;

        // halt_commit_i in RUN has no effect.
        halt_commit_i = 1'b1;
        fetchCycle(16'h0040, 16'h0041);
        halt_commit_i = 1'b0;
        checkCtl("commit_in_run", 1'b1, 1'b0);

        // Wait states insert bubbles without skipping pc 8.
        redirectTo(16'd8);
        im_ready_i = 1'b0;
        bubbleCycle(16'd8);
        bubbleCycle(16'd8);
        bubbleCycle(16'd8);
        im_ready_i = 1'b1;
        fetchCycle(16'd8, 16'd9);
        fetchCycle(16'd9, 16'd10);

        // HLT: drain, commit, halted, then inputs ignored until reset.
        fetchCycle(16'd10, 16'd10);
        checkCtl("drain_ctl", 1'b0, 1'b0);
        bubbleCycle(16'd10);
        halt_commit_i = 1'b1;
        bubbleCycle(16'd10);
        halt_commit_i = 1'b0;
        checkCtl("halted_ctl", 1'b0, 1'b1);
        redirect_i = 1'b1; redirect_pc_i = 16'h0040; stall_i = 1'b1;
        bubbleCycle(16'd10);
        redirect_i = 1'b0; stall_i = 1'b0;
        checkCtl("halted_ignore", 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkVal("rst_halted_pc", {32'd0, pc_o}, 48'd0);
        checkCtl("rst_halted_ctl", 1'b1, 1'b0);

        // Redirect beats halt_commit_i in DRAIN.
        redirectTo(16'd10);
        fetchCycle(16'd10, 16'd10);
        halt_commit_i = 1'b1;
        redirectTo(16'h0020);
        halt_commit_i = 1'b0;
        checkCtl("drain_redirect", 1'b1, 1'b0);
        fetchCycle(16'h0020, 16'h0021);

        // PC wrap at 16'hFFFF.
        redirectTo(16'hFFFF);
        fetchCycle(16'hFFFF, 16'h0000);

        checkVal("final_q", {16'd0, 32'(expQ.size())}, 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
